// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses framed command packets from a UART receiver.
// Frame: 0xAA 0x55 CMD LEN payload[LEN] CHK, CHK = (CMD+LEN+payload) mod 256.
// A good frame with CMD=0x01, LEN=2 reprograms the receiver configuration.
//
// Handshake: din is consumed only on cycles where din_vld is high; there is
// no back-pressure, so every din_vld byte is accepted in the cycle it arrives.
// frame_vld, err and cfg_upd are single-cycle pulses in the cycle after the
// deciding byte; frame_* and err_code hold their values until overwritten.
module uart_frame_ctrl #(
    parameter logic [15:0] TIMEOUT_CYC   = 16'd50000,
    parameter logic        DEF_SEL_CHECK = 1'b0,
    parameter logic        DEF_PARITY    = 1'b0,
    parameter logic [6:0]  DEF_SMPL_CLKP = 7'd86
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic        sel_check,
    output logic        parity_check,
    output logic [6:0]  smpl_clkp,
    output logic        cfg_upd,
    output logic        frame_vld,
    output logic [7:0]  frame_cmd,
    output logic [3:0]  frame_len,
    output logic [63:0] frame_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR2 = 3'd1,
        S_CMD  = 3'd2,
        S_LEN  = 3'd3,
        S_DATA = 3'd4,
        S_CHK  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    state_t       state_q;
    logic [15:0]  tmo_q;
    logic [3:0]   idx_q;
    logic [3:0]   len_q;
    logic [7:0]   cmd_q;
    logic [7:0]   sum_q;
    logic [63:0]  buf_q;

    logic         sel_check_q;
    logic         parity_check_q;
    logic [6:0]   smpl_clkp_q;
    logic         cfg_upd_q;
    logic         frame_vld_q;
    logic [7:0]   frame_cmd_q;
    logic [3:0]   frame_len_q;
    logic [63:0]  frame_data_q;
    logic         err_q;
    logic [1:0]   err_code_q;

    logic         tmo_hit;
    logic [7:0]   sum_d;
    logic         last_byte;

    // Timeout fires only on an idle cycle; a byte at the terminal count wins.
    assign tmo_hit   = (state_q != S_IDLE) && !din_vld && (tmo_q == TIMEOUT_CYC);
    assign sum_d     = sum_q + din;
    assign last_byte = (idx_q == (len_q - 4'd1));

    // Frame parser FSM together with its counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tmo_q          <= 16'd0;
            idx_q          <= 4'd0;
            len_q          <= 4'd0;
            cmd_q          <= 8'd0;
            sum_q          <= 8'd0;
            buf_q          <= 64'd0;
            sel_check_q    <= DEF_SEL_CHECK;
            parity_check_q <= DEF_PARITY;
            smpl_clkp_q    <= DEF_SMPL_CLKP;
            cfg_upd_q      <= 1'b0;
            frame_vld_q    <= 1'b0;
            frame_cmd_q    <= 8'd0;
            frame_len_q    <= 4'd0;
            frame_data_q   <= 64'd0;
            err_q          <= 1'b0;
            err_code_q     <= 2'b00;
        end else begin
            frame_vld_q <= 1'b0;
            err_q       <= 1'b0;
            cfg_upd_q   <= 1'b0;

            if (state_q == S_IDLE || din_vld || tmo_hit) begin
                tmo_q <= 16'd0;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (tmo_hit) begin
                state_q    <= S_IDLE;
                err_q      <= 1'b1;
                err_code_q <= ERR_TMO;
            end else if (din_vld) begin
                case (state_q)
                    S_IDLE: begin
                        if (din == 8'hAA) state_q <= S_HDR2;
                    end
                    S_HDR2: begin
                        // A repeated 0xAA may be the real start of the frame.
                        if (din == 8'h55) begin
                            state_q <= S_CMD;
                        end else if (din != 8'hAA) begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_CMD: begin
                        cmd_q   <= din;
                        sum_q   <= din;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        if (din > 8'd8) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_LEN;
                            state_q    <= S_IDLE;
                        end else begin
                            // Clearing on every legal length keeps unused bytes zero, LEN=0 included.
                            len_q   <= din[3:0];
                            sum_q   <= sum_d;
                            buf_q   <= 64'd0;
                            idx_q   <= 4'd0;
                            state_q <= (din == 8'd0) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        buf_q[{idx_q[2:0], 3'b000} +: 8] <= din;
                        sum_q <= sum_d;
                        idx_q <= idx_q + 4'd1;
                        if (last_byte) state_q <= S_CHK;
                    end
                    S_CHK: begin
                        if (din == sum_q) begin
                            frame_vld_q  <= 1'b1;
                            frame_cmd_q  <= cmd_q;
                            frame_len_q  <= len_q;
                            frame_data_q <= buf_q;
                            if (cmd_q == 8'h01 && len_q == 4'd2) begin
                                sel_check_q    <= buf_q[0];
                                parity_check_q <= buf_q[1];
                                smpl_clkp_q    <= buf_q[14:8];
                                cfg_upd_q      <= 1'b1;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CHK;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sel_check    = sel_check_q;
    assign parity_check = parity_check_q;
    assign smpl_clkp    = smpl_clkp_q;
    assign cfg_upd      = cfg_upd_q;
    assign frame_vld    = frame_vld_q;
    assign frame_cmd    = frame_cmd_q;
    assign frame_len    = frame_len_q;
    assign frame_data   = frame_data_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, 16'd50000: inter-byte timeout, in clk cycles.
REQ-002 Parameter DEF_SEL_CHECK, 1'b0: reset value of sel_check.
REQ-003 Parameter DEF_PARITY, 1'b0: reset value of parity_check.
REQ-004 Parameter DEF_SMPL_CLKP, 7'd86: reset value of smpl_clkp.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock; all logic on posedge.
REQ-007 rst_n  input  1  synchronous reset, 0 = active.
REQ-008 din  input  8  received byte from the UART receiver.
REQ-009 din_vld  input  1  one-cycle strobe qualifying din.
REQ-010 sel_check  output  1  parity enable driven to the receiver.
REQ-011 parity_check  output  1  parity type driven to the receiver (1 = odd).
REQ-012 smpl_clkp  output  7  sample divider driven to the receiver.
REQ-013 cfg_upd  output  1  one-cycle pulse when the configuration registers change.
REQ-014 frame_vld  output  1  one-cycle pulse marking a good frame.
REQ-015 frame_cmd  output  8  command byte of the last good frame.
REQ-016 frame_len  output  4  payload length of the last good frame (0..8).
REQ-017 frame_data  output  64  payload of the last good frame; byte i at [8i+7:8i]; unused bytes 0.
REQ-018 err  output  1  one-cycle pulse on a frame error.
REQ-019 err_code  output  2  error cause: 01 checksum, 10 length, 11 timeout; held until the next err.
REQ-020 busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 Frame format SHALL be 0xAA, 0x55, CMD, LEN, LEN payload bytes, CHK, where CHK = (CMD+LEN+sum of payload) mod 256.
REQ-022 The FSM SHALL have states IDLE, HDR2, CMD, LEN, DATA and CHK; a state advances only on a din_vld cycle.
REQ-023 IDLE: 0xAA goes to HDR2; any other byte is ignored.
REQ-024 HDR2: 0x55 goes to CMD; 0xAA stays in HDR2; any other byte returns to IDLE with no err.
REQ-025 CMD: store the byte, seed the running sum with it, go to LEN.
REQ-026 LEN: a value >8 pulses err with code 10 and returns to IDLE; 0 goes to CHK; 1..8 clears the payload buffer, zeroes the byte index and goes to DATA.
REQ-027 DATA: write the byte at the current index, add it to the sum, and go to CHK after the LEN-th byte.
REQ-028 CHK: on a match, pulse frame_vld and update frame_cmd/len/data; on a mismatch, pulse err with code 01; both cases return to IDLE.
REQ-029 frame_vld and err SHALL be registered and assert the cycle after the deciding din_vld; they are never high together.
REQ-030 On a good frame with CMD=0x01 and LEN=2, in the same cycle as frame_vld: sel_check<=data0[0], parity_check<=data0[1], smpl_clkp<=data1[6:0], and cfg_upd pulses.
REQ-031 CMD=0x01 with LEN≠2 SHALL still produce frame_vld, with no configuration change and no cfg_upd.
REQ-032 A timeout counter SHALL clear on every din_vld and in IDLE, and increment each non-IDLE cycle without din_vld.
REQ-033 When the timeout counter equals TIMEOUT_CYC with no din_vld, the block returns to IDLE and pulses err with code 11.
REQ-034 If din_vld coincides with the terminal count, the byte SHALL be processed and no timeout SHALL be raised.
REQ-035 Configuration outputs SHALL change only via REQ-030 or reset.

Reset
REQ-036 While rst_n=0 at a clk edge: state=IDLE, counters=0, payload buffer=0, sum=0, frame_vld/err/cfg_upd/busy=0, frame_cmd/len/data=0, err_code=00, sel_check=DEF_SEL_CHECK, parity_check=DEF_PARITY, smpl_clkp=DEF_SMPL_CLKP.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame, produce no frame_vld or err, and require a fresh 0xAA after release.

Verification
REQ-038 Send bytes AA 55 01 02 03 56 5C -> frame_vld 1 cycle after 5C; frame_cmd=01, frame_len=2, frame_data=64'h5603; cfg_upd=1; sel_check=1, parity_check=1, smpl_clkp=7'h56.
REQ-039 Send AA 55 10 00 10 -> frame_vld, frame_len=0, frame_data=0, no cfg_upd; then AA 55 10 00 11 -> err with err_code=01 and no frame_vld.
REQ-040 Send AA 55 10 09 -> err with err_code=10 after the 09 byte; a following full good frame is accepted.
REQ-041 Send AA 55 10 then idle for TIMEOUT_CYC cycles -> err with err_code=11 and busy=0; repeat with a byte arriving exactly at the terminal count -> no err.
REQ-042 Send AA AA 55 20 01 7F A0 -> frame_vld with frame_data=64'h7F; send AA 13 -> no output and busy=0.
REQ-043 Assert rst_n=0 after AA 55 01 -> no err, all outputs at reset values; then send the REQ-038 sequence -> a good frame is accepted.
